// File: rtl/aes_pkg.sv
// Shared AES definitions: key-generator FSM states, round count,
// round constants and the word-rotation helper.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // AES-256: 14 rounds, round keys 0..14 (key 0 is never written).
  localparam int ROUNDS = 14;

  // Rcon bytes indexed by k = r/2; entry 0 is unused padding.
  localparam logic [7:0][7:0] RCON = {
    8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
  };

  // Cyclic left rotation by one byte: {a0,a1,a2,a3} -> {a1,a2,a3,a0}.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform. Purely combinational.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ aa;
      end else begin
        p = p;
      end
      if (aa[7]) begin
        aa = {aa[6:0], 1'b0} ^ 8'h1b;
      end else begin
        aa = {aa[6:0], 1'b0};
      end
    end
    return p;
  endfunction

  // Inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Affine transform: a ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  function automatic logic [7:0] affine(input logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
             ^ {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  assign out_byte = affine(gf_inv(in_byte));

endmodule

// File: rtl/decipher_key_gen.sv
// Iterative AES-256 key expansion: captures the cipher key on start and
// emits round keys 1..14 (addresses 0..13), one per clock, to the
// decipher key memory write port.
module decipher_key_gen
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] key_in,
  output logic         dec_key_gen,
  output logic [3:0]   round,
  output logic [127:0] round_key_out,
  output logic         busy,
  output logic         done
);

  // r counts 1..14 for the writes; r = 15 is the closing cycle that
  // raises done and moves to FIN.
  localparam logic [3:0] LAST_R = 4'(ROUNDS + 1);

  state_t        state_r, state_s;
  logic [127:0]  prev_r, prev_s;
  logic [127:0]  cur_r, cur_s;
  logic [3:0]    r_r, r_s;
  logic          wr_r, wr_s;
  logic [3:0]    round_r, round_s;
  logic [127:0]  rk_r, rk_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;

  logic [31:0]   sub_s;
  logic [31:0]   t_s;
  logic [31:0]   n0_s, n1_s, n2_s, n3_s;
  logic [127:0]  next_s;

  // SubWord on cur.w3; SubWord and RotWord commute, so one set serves both.
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (cur_r[8*g +: 8]),
      .out_byte (sub_s[8*g +: 8])
    );
  end

  // Key-schedule step f(prev, cur, r): even r rotates and adds Rcon.
  always_comb begin
    if (r_r[0] == 1'b0) begin
      t_s = rot_word(sub_s) ^ {RCON[r_r[3:1]], 24'h000000};
    end else begin
      t_s = sub_s;
    end
    n0_s   = prev_r[127:96] ^ t_s;
    n1_s   = prev_r[95:64]  ^ n0_s;
    n2_s   = prev_r[63:32]  ^ n1_s;
    n3_s   = prev_r[31:0]   ^ n2_s;
    next_s = {n0_s, n1_s, n2_s, n3_s};
  end

  // Next-state and next-output logic; every output is re-registered.
  always_comb begin
    state_s = state_r;
    prev_s  = prev_r;
    cur_s   = cur_r;
    r_s     = r_r;
    wr_s    = 1'b0;
    round_s = round_r;
    rk_s    = rk_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          prev_s  = key_in[255:128];
          cur_s   = key_in[127:0];
          r_s     = 4'd1;
          busy_s  = 1'b1;
          state_s = GEN;
        end else begin
          state_s = IDLE;
        end
      end
      GEN: begin
        if (r_r == LAST_R) begin
          busy_s  = 1'b0;
          done_s  = 1'b1;
          state_s = FIN;
        end else if (r_r == 4'd1) begin
          // Round key 1 is the low half of the cipher key, written as is.
          wr_s    = 1'b1;
          round_s = 4'd0;
          rk_s    = cur_r;
          r_s     = r_r + 4'd1;
        end else begin
          wr_s    = 1'b1;
          round_s = r_r - 4'd1;
          rk_s    = next_s;
          prev_s  = cur_r;
          cur_s   = next_s;
          r_s     = r_r + 4'd1;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, key history and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      prev_r  <= 128'h0;
      cur_r   <= 128'h0;
      r_r     <= 4'd0;
      wr_r    <= 1'b0;
      round_r <= 4'd0;
      rk_r    <= 128'h0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      prev_r  <= prev_s;
      cur_r   <= cur_s;
      r_r     <= r_s;
      wr_r    <= wr_s;
      round_r <= round_s;
      rk_r    <= rk_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign dec_key_gen   = wr_r;
  assign round         = round_r;
  assign round_key_out = rk_r;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule

// File: tb/tb_decipher_key_gen.sv
// Self-checking bench for decipher_key_gen against a FIPS-197 style
// key-expansion model built from a brute-force S-box table.
module tb_decipher_key_gen;

  localparam logic [255:0] KA3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KC3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [255:0] key_in;
  logic         dec_key_gen;
  logic [3:0]   round;
  logic [127:0] round_key_out;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0]   sbox_tbl [256];
  logic [3:0]   q_round[$];
  logic [127:0] q_key[$];
  int           q_cyc[$];
  int           done_q[$];
  logic         done_busy_q[$];

  decipher_key_gen dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .key_in        (key_in),
    .dec_key_gen   (dec_key_gen),
    .round         (round),
    .round_key_out (round_key_out),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Edge counter used to time strobes relative to the accepting edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every write strobe and done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (dec_key_gen) begin
      q_round.push_back(round);
      q_key.push_back(round_key_out);
      q_cyc.push_back(cyc);
    end
    if (done) begin
      done_q.push_back(cyc);
      done_busy_q.push_back(busy);
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    while (y != 8'h00) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] ref_sub(input logic [31:0] w);
    return {sbox_tbl[w[31:24]], sbox_tbl[w[23:16]], sbox_tbl[w[15:8]], sbox_tbl[w[7:0]]};
  endfunction

  // Textbook AES-256 expansion into w[0..59]; returns round key r.
  function automatic logic [127:0] ref_rk(input logic [255:0] key, input int r);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = ref_sub({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
        rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (i % 8 == 4) begin
        tmp = ref_sub(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  task automatic clear_q();
    q_round.delete();
    q_key.delete();
    q_cyc.delete();
    done_q.delete();
    done_busy_q.delete();
  endtask

  // One-cycle start pulse; t0 is the edge count of the accepting edge.
  task automatic launch(input logic [255:0] k, output int t0);
    @(negedge clk);
    start  = 1'b1;
    key_in = k;
    @(negedge clk);
    t0    = cyc;
    start = 1'b0;
    chk("busy_after_start", 128'(busy), 128'(1));
  endtask

  task automatic run_gen(input bit wiggle, input int n);
    repeat (n) begin
      @(negedge clk);
      if (wiggle) key_in = rand256();
    end
  endtask

  // 14 strobes from queue slot base, rounds 0..13 on edges t0+1..t0+14,
  // and done (with busy low) on edge t0+15.
  task automatic check_seq(input logic [255:0] k, input int t0, input int base,
                           input int dbase, input string tag);
    for (int j = 0; j < 14; j++) begin
      if (base + j < q_round.size()) begin
        chk({tag, "_round"}, 128'(q_round[base+j]), 128'(j));
        chk({tag, "_key"}, q_key[base+j], ref_rk(k, j + 1));
        chk({tag, "_strobe_time"}, 128'(q_cyc[base+j] - t0), 128'(j + 1));
      end else begin
        chk({tag, "_strobe_count"}, 128'(q_round.size()), 128'(base + j + 1));
        break;
      end
    end
    if (dbase < done_q.size()) begin
      chk({tag, "_done_time"}, 128'(done_q[dbase] - t0), 128'(15));
      chk({tag, "_busy_at_done"}, 128'(done_busy_q[dbase]), 128'(0));
    end else begin
      chk({tag, "_done_count"}, 128'(done_q.size()), 128'(dbase + 1));
    end
  endtask

  initial begin
    int t0;
    int t0b;
    logic [255:0] k;
    bit wig;

    // S-box table: brute-force inverse, then the bitwise affine map.
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] b;
      for (int y = 1; y < 256; y++)
        if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8]
             ^ inv[(i+7)%8] ^ ((8'h63 >> i) & 8'h01) != 8'h00;
      sbox_tbl[x] = b;
    end

    reset  = 1'b1;
    start  = 1'b0;
    key_in = 256'h0;
    repeat (3) @(negedge clk);
    chk("rst_dec_key_gen", 128'(dec_key_gen), 128'(0));
    chk("rst_round", 128'(round), 128'(0));
    chk("rst_round_key_out", round_key_out, 128'h0);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    reset = 1'b0;

    // FIPS-197 A.3 key with known-answer spot checks.
    clear_q();
    launch(KA3, t0);
    run_gen(1'b0, 18);
    check_seq(KA3, t0, 0, 0, "a3");
    chk("a3_strobes", 128'(q_key.size()), 128'(14));
    if (q_key.size() >= 14) begin
      chk("a3_r0_kat", q_key[0], 128'h1f352c073b6108d72d9810a30914dff4);
      chk("a3_r1_kat", q_key[1], 128'h9ba354118e6925afa51a8b5f2067fcde);
      chk("a3_r13_kat", q_key[13], 128'hfe4890d1e6188d0b046df344706c631e);
    end

    // C.3 key, key_in scrambled every cycle after capture.
    clear_q();
    launch(KC3, t0);
    run_gen(1'b1, 18);
    check_seq(KC3, t0, 0, 0, "c3");
    if (q_key.size() >= 14)
      chk("c3_r13_kat", q_key[13], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // Back-to-back: second start raised in the done cycle (ignored in FIN)
    // and held one more cycle, so it is accepted 17 edges after the first.
    clear_q();
    launch(KA3, t0);
    run_gen(1'b0, 15);
    start  = 1'b1;
    key_in = KC3;
    @(negedge clk);
    @(negedge clk);
    t0b   = cyc;
    start = 1'b0;
    run_gen(1'b0, 18);
    check_seq(KA3, t0, 0, 0, "b2b_a3");
    check_seq(KC3, t0b, 14, 1, "b2b_c3");
    chk("b2b_accept_gap", 128'(t0b - t0), 128'(17));
    chk("b2b_strobes", 128'(q_key.size()), 128'(28));

    // start held for 20 edges: one sequence, then one more after FIN.
    clear_q();
    k = rand256();
    @(negedge clk);
    start  = 1'b1;
    key_in = k;
    @(negedge clk);
    t0 = cyc;
    repeat (19) @(negedge clk);
    start = 1'b0;
    run_gen(1'b0, 20);
    check_seq(k, t0, 0, 0, "held_1");
    check_seq(k, t0 + 17, 14, 1, "held_2");
    chk("held_strobes", 128'(q_key.size()), 128'(28));
    chk("held_dones", 128'(done_q.size()), 128'(2));

    // Reset sampled at T6: five writes happened, then nothing.
    clear_q();
    k = rand256();
    launch(k, t0);
    run_gen(1'b0, 5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_strobe", 128'(dec_key_gen), 128'(0));
    run_gen(1'b0, 20);
    chk("midrst_strobes", 128'(q_key.size()), 128'(5));
    chk("midrst_dones", 128'(done_q.size()), 128'(0));
    for (int j = 0; j < 5 && j < q_key.size(); j++)
      chk("midrst_key", q_key[j], ref_rk(k, j + 1));

    // Reset and start together: reset wins, nothing is generated.
    clear_q();
    @(negedge clk);
    reset  = 1'b1;
    start  = 1'b1;
    key_in = rand256();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", 128'(busy), 128'(0));
    run_gen(1'b0, 20);
    chk("rst_start_strobes", 128'(q_key.size()), 128'(0));

    // Random keys, randomly scrambling key_in during generation.
    for (int n = 0; n < 6; n++) begin
      clear_q();
      k   = rand256();
      wig = 1'($urandom_range(1, 0));
      launch(k, t0);
      run_gen(wig, 18);
      check_seq(k, t0, 0, 0, "rand");
      chk("rand_strobes", 128'(q_key.size()), 128'(14));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
